// File: rtl/dtc_therm_decoder.sv
// Two-stage streaming decoder for thermometer-coded classifier outputs.
// S1 captures the raw code word, S2 holds the decoded level/bubble flag and drives the output.
module dtc_therm_decoder #(
    parameter int W  = 10,
    parameter int LW = 4,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] out_level,
    output logic          out_err,
    output logic [EW-1:0] err_count,
    input  logic          clr_count
);

    localparam logic [EW-1:0] CNT_MAX = '1;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // A producer holds valid and its payload stable until that edge; ready never
    // depends on the valid of the same interface, so there are no combinational loops.
    logic          s1_valid;
    logic [W-1:0]  s1_code;
    logic          s2_valid;
    logic          s2_ready;
    logic          s1_advance;
    logic          in_fire;
    logic [LW-1:0] dec_level;
    logic          dec_err;
    logic          seen_zero;

    assign s2_ready   = !s2_valid || out_ready;
    assign s1_advance = s1_valid && s2_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = s2_valid;

    // Level is the first zero scanning upward; any one above that zero is a bubble.
    always_comb begin
        dec_level = LW'(W);
        dec_err   = 1'b0;
        seen_zero = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!s1_code[i]) begin
                if (!seen_zero) begin
                    dec_level = LW'(i);
                end
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                dec_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
        end else begin
            if (in_fire) begin
                s1_code <= in_code;
            end
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_level <= '0;
            out_err   <= 1'b0;
        end else begin
            if (s1_advance) begin
                s2_valid  <= 1'b1;
                out_level <= dec_level;
                out_err   <= dec_err;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Clear wins over a same-edge increment; the count sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            err_count <= '0;
        end else if (s1_advance && dec_err && (err_count != CNT_MAX)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dtc_therm_decoder.sv
// Directed and random checks of dtc_therm_decoder against an independent decode model.
module tb_dtc_therm_decoder;

    localparam int W  = 10;
    localparam int LW = 4;
    localparam int EW = 8;
    localparam int N_RAND = 10000;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_code;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_level;
    logic          out_err;
    logic [EW-1:0] err_count;
    logic          clr_count;

    int checks;
    int errors;
    int n_out;
    logic [LW:0] exp_q[$];

    dtc_therm_decoder #(.W(W), .LW(LW), .EW(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_level (out_level),
        .out_err   (out_err),
        .err_count (err_count),
        .clr_count (clr_count)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode: count ones from bit 0, then compare with the ideal code of that level.
    function automatic logic [LW:0] model(input logic [W-1:0] c);
        int          lvl;
        logic [W:0]  legal;
        logic        err;
        lvl = 0;
        while (lvl < W && c[lvl]) lvl++;
        legal = (11'd1 << lvl) - 11'd1;
        err = ({1'b0, c} != legal);
        return {err, LW'(lvl)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clr_count = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        n_out = 0;
    endtask

    // driver task: one clock with scoreboard push on input transfer, pop/compare on output transfer
    task automatic drive_cycle(input logic iv, input logic [W-1:0] code, input logic ordy,
                               output logic took);
        logic [LW:0] e;
        in_valid = iv; in_code = code; out_ready = ordy;
        #1;
        took = in_valid && in_ready;
        if (out_valid && out_ready) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_level", out_level, e[LW-1:0]);
                check("sb_err", out_err, e[LW]);
            end
            n_out++;
        end
        if (took) exp_q.push_back(model(code));
        step();
    endtask

    logic [W-1:0] bp_words [5];
    logic         took;
    logic [W-1:0] word;
    int           sent;
    int           nbub;
    int           cyc;
    int           exp_cnt;

    initial begin
        checks = 0; errors = 0;
        bp_words[0] = 10'h001; bp_words[1] = 10'h003; bp_words[2] = 10'h00F;
        bp_words[3] = 10'h0FF; bp_words[4] = 10'h005;

        // reset state (sampled while rst is still high)
        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clr_count = 1'b0;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_level", out_level, 0);
        check("rst_err", out_err, 0);
        check("rst_count", err_count, 0);

        // legal codes back to back
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_code = 10'h000; step();
        in_code = 10'h07F; step();
        check("legal_v0", out_valid, 1); check("legal_l0", out_level, 0); check("legal_e0", out_err, 0);
        in_code = 10'h3FF; step();
        check("legal_v1", out_valid, 1); check("legal_l1", out_level, 7); check("legal_e1", out_err, 0);
        in_valid = 1'b0; in_code = 'x; step();
        check("legal_v2", out_valid, 1); check("legal_l2", out_level, 10); check("legal_e2", out_err, 0);
        check("legal_count", err_count, 0);
        step();
        check("legal_drained", out_valid, 0);

        // bubble codes
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_code = 10'h05F; step();
        in_code = 10'h201; step();
        check("bub_l0", out_level, 5); check("bub_e0", out_err, 1);
        in_valid = 1'b0; step();
        check("bub_l1", out_level, 1); check("bub_e1", out_err, 1);
        check("bub_count", err_count, 2);

        // backpressure: out_ready low for cycles 2-6
        do_reset();
        sent = 0;
        for (int c = 0; c < 7; c++) begin
            if (c >= 2) begin
                in_valid = 1'b1; in_code = bp_words[sent]; out_ready = 1'b0; #1;
                check("bp_in_ready_low", in_ready, 0);
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_level", out_level, 1);
                check("bp_hold_err", out_err, 0);
            end
            drive_cycle(1'b1, bp_words[sent], 1'b0, took);
            if (took) sent++;
        end
        check("bp_accepted_two", sent, 2);
        cyc = 0;
        while ((sent < 5 || exp_q.size() != 0) && cyc < 50) begin
            drive_cycle(sent < 5, (sent < 5) ? bp_words[sent] : '0, 1'b1, took);
            if (took) sent++;
            cyc++;
        end
        check("bp_no_timeout", cyc < 50, 1);
        check("bp_out_count", n_out, 5);

        // saturation, then clear racing an increment
        do_reset();
        for (int k = 0; k < 300; k++) drive_cycle(1'b1, 10'h002, 1'b1, took);
        drive_cycle(1'b0, '0, 1'b1, took);
        drive_cycle(1'b0, '0, 1'b1, took);
        check("sat_count", err_count, 255);
        drive_cycle(1'b1, 10'h002, 1'b1, took);
        drive_cycle(1'b0, '0, 1'b1, took);
        drive_cycle(1'b0, '0, 1'b1, took);
        check("sat_hold", err_count, 255);
        drive_cycle(1'b1, 10'h002, 1'b1, took);
        clr_count = 1'b1;
        drive_cycle(1'b1, 10'h004, 1'b1, took);
        clr_count = 1'b0;
        check("clr_priority", err_count, 0);
        drive_cycle(1'b0, '0, 1'b1, took);
        check("clr_then_inc", err_count, 1);
        check("clr_pipe_kept", out_valid, 1);
        check("clr_pipe_level", out_level, 0);

        // reset with both stages full and output stalled
        do_reset();
        drive_cycle(1'b1, 10'h005, 1'b0, took);
        drive_cycle(1'b1, 10'h00F, 1'b0, took);
        in_valid = 1'b0; #1;
        check("mid_full", in_ready, 0);
        check("mid_count_before", err_count, 1);
        rst = 1'b1; step(); rst = 1'b0;
        check("mid_out_valid", out_valid, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_count", err_count, 0);
        exp_q.delete();
        out_ready = 1'b1; in_valid = 1'b1; in_code = 10'h03F; step();
        in_valid = 1'b0; in_code = 'x; #1;
        check("mid_lat1_empty", out_valid, 0);
        step();
        check("mid_valid", out_valid, 1);
        check("mid_level", out_level, 6);
        check("mid_err", out_err, 0);

        // random stress against the scoreboard
        do_reset();
        sent = 0; nbub = 0; cyc = 0;
        word = 10'(($urandom_range(0, 1) != 0) ? ((11'd1 << $urandom_range(0, W)) - 11'd1) : $urandom);
        while (sent < N_RAND && cyc < 80000) begin
            logic iv;
            iv = 1'($urandom_range(0, 1));
            drive_cycle(iv, iv ? word : 10'($urandom), 1'($urandom_range(0, 1)), took);
            if (took) begin
                if (model(word) >= 5'h10) nbub++;
                sent++;
                word = 10'(($urandom_range(0, 1) != 0) ? ((11'd1 << $urandom_range(0, W)) - 11'd1) : $urandom);
            end
            cyc++;
        end
        check("rand_all_sent", sent, N_RAND);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            drive_cycle(1'b0, '0, 1'b1, took);
            cyc++;
        end
        check("rand_drained", exp_q.size(), 0);
        check("rand_out_count", n_out, N_RAND);
        exp_cnt = (nbub > 255) ? 255 : nbub;
        check("rand_err_count", err_count, exp_cnt);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
